// File: rtl/jk_bank_ctrl.sv
// Command sequencer for an external bank of JK flip-flops: set/clear/toggle/load
// in one drive cycle, or synchronous up/down counting for cmd_len cycles.
module jk_bank_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic [CNT_W-1:0] cmd_len,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   // Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE, and a requester holds cmd_* until then.
   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_COUNT, S_DONE} state_t;

   localparam logic [2:0] OP_SET = 3'd1;
   localparam logic [2:0] OP_CLR = 3'd2;
   localparam logic [2:0] OP_TGL = 3'd3;
   localparam logic [2:0] OP_LD  = 3'd4;
   localparam logic [2:0] OP_UP  = 3'd5;
   localparam logic [2:0] OP_DN  = 3'd6;

   state_t           state;
   logic [2:0]       op;
   logic [WIDTH-1:0] arg;
   logic [CNT_W-1:0] rem;
   logic [WIDTH-1:0] t_up, t_dn;

   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         op        <= '0;
         arg       <= '0;
         rem       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cmd_ready <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op        <= cmd_op;
                  arg       <= cmd_arg;
                  busy      <= 1'b1;
                  cmd_ready <= 1'b0;
                  case (cmd_op)
                     OP_SET, OP_CLR, OP_TGL, OP_LD: state <= S_DRIVE;
                     OP_UP, OP_DN: begin
                        if (cmd_len != '0) begin
                           state <= S_COUNT;
                           rem   <= cmd_len;
                        end else begin
                           state <= S_DONE;
                           done  <= 1'b1;
                        end
                     end
                     default: begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end
                  endcase
               end
            end
            S_DRIVE: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_COUNT: begin
               rem <= rem - CNT_W'(1);
               if (rem == CNT_W'(1)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   // Ripple AND chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      t_up    = '0;
      t_dn    = '0;
      t_up[0] = 1'b1;
      t_dn[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         t_up[i] = t_up[i-1] & q_in[i-1];
         t_dn[i] = t_dn[i-1] & ~q_in[i-1];
      end
   end

   // J/K decode straight from the state register so reset drops them at once.
   always_comb begin
      j_out = '0;
      k_out = '0;
      case (state)
         S_DRIVE: begin
            case (op)
               OP_SET: j_out = arg;
               OP_CLR: k_out = arg;
               OP_TGL: begin
                  j_out = arg;
                  k_out = arg;
               end
               OP_LD: begin
                  j_out = arg;
                  k_out = ~arg;
               end
               default: begin
                  j_out = '0;
                  k_out = '0;
               end
            endcase
         end
         S_COUNT: begin
            j_out = (op == OP_DN) ? t_dn : t_up;
            k_out = (op == OP_DN) ? t_dn : t_up;
         end
         default: begin
            j_out = '0;
            k_out = '0;
         end
      endcase
   end

endmodule
